// File: rtl/alu_rf_datapath_pkg.sv
// Shared constants for the RV32I register-file/ALU datapath: widths and ALU opcodes.
package alu_rf_datapath_pkg;

   localparam int XLEN   = 32;
   localparam int NREG   = 32;
   localparam int RIDX_W = 5;
   localparam int ALUC_W = 5;

   // Code 0 is ADD so an all-zero bubble control word is a harmless add.
   localparam logic [ALUC_W-1:0] ALU_ADD   = 5'd0;
   localparam logic [ALUC_W-1:0] ALU_SUB   = 5'd1;
   localparam logic [ALUC_W-1:0] ALU_SLL   = 5'd2;
   localparam logic [ALUC_W-1:0] ALU_SLT   = 5'd3;
   localparam logic [ALUC_W-1:0] ALU_SLTU  = 5'd4;
   localparam logic [ALUC_W-1:0] ALU_XOR   = 5'd5;
   localparam logic [ALUC_W-1:0] ALU_SRL   = 5'd6;
   localparam logic [ALUC_W-1:0] ALU_SRA   = 5'd7;
   localparam logic [ALUC_W-1:0] ALU_OR    = 5'd8;
   localparam logic [ALUC_W-1:0] ALU_AND   = 5'd9;
   localparam logic [ALUC_W-1:0] ALU_PASSB = 5'd10;

endpackage

// File: rtl/alu_rf_datapath_alu_core.sv
// Purely combinational RV32I ALU; unused opcodes produce zero.
module alu_core
   import alu_rf_datapath_pkg::*;
(
   input  logic [XLEN-1:0]   a,
   input  logic [XLEN-1:0]   b,
   input  logic [ALUC_W-1:0] op,
   output logic [XLEN-1:0]   y
);

   logic signed [XLEN-1:0] a_s;
   logic signed [XLEN-1:0] b_s;
   logic [4:0]             shamt;

   assign a_s   = a;
   assign b_s   = b;
   assign shamt = b[4:0];

   always_comb begin
      y = '0;
      case (op)
         ALU_ADD:   y = a + b;
         ALU_SUB:   y = a - b;
         ALU_SLL:   y = a << shamt;
         ALU_SLT:   y = (a_s < b_s) ? 32'd1 : 32'd0;
         ALU_SLTU:  y = (a < b) ? 32'd1 : 32'd0;
         ALU_XOR:   y = a ^ b;
         ALU_SRL:   y = a >> shamt;
         ALU_SRA:   y = a_s >>> shamt;
         ALU_OR:    y = a | b;
         ALU_AND:   y = a & b;
         ALU_PASSB: y = b;
         default:   y = '0;
      endcase
   end

endmodule

// File: rtl/alu_rf_datapath.sv
// RV32I register file (2 combinational read ports with write-first bypass, 1 write port) plus ALU.
module alu_rf_datapath
   import alu_rf_datapath_pkg::*;
(
   input  logic              CLK,
   input  logic              RSTN,
   input  logic [RIDX_W-1:0] RNUM1,
   output logic [XLEN-1:0]   RDATA1,
   input  logic [RIDX_W-1:0] RNUM2,
   output logic [XLEN-1:0]   RDATA2,
   input  logic [RIDX_W-1:0] WNUM,
   input  logic [XLEN-1:0]   WDATA,
   input  logic [XLEN-1:0]   ALU_A,
   input  logic [XLEN-1:0]   ALU_B,
   input  logic [ALUC_W-1:0] ALU_C,
   output logic [XLEN-1:0]   ALU_Y
);

   // Entry 0 exists only to keep indexing simple; it is never written or read out.
   logic [XLEN-1:0] rf [0:NREG-1];

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         for (int i = 0; i < NREG; i++) rf[i] <= '0;
      end else if (WNUM != '0) begin
         rf[WNUM] <= WDATA;
      end
   end

   // x0 reads zero; a same-cycle write to the read index is forwarded.
   function automatic logic [XLEN-1:0] rd_port(
      input logic [RIDX_W-1:0] rnum,
      input logic [RIDX_W-1:0] wnum,
      input logic [XLEN-1:0]   wdata,
      input logic [XLEN-1:0]   entry
   );
      if (rnum == '0)        return '0;
      else if (rnum == wnum) return wdata;
      else                   return entry;
   endfunction

   always_comb begin
      RDATA1 = rd_port(RNUM1, WNUM, WDATA, rf[RNUM1]);
      RDATA2 = rd_port(RNUM2, WNUM, WDATA, rf[RNUM2]);
   end

   alu_core u_alu (
      .a  (ALU_A),
      .b  (ALU_B),
      .op (ALU_C),
      .y  (ALU_Y)
   );

endmodule

// File: tb/tb_alu_rf_datapath.sv
// Self-checking bench for alu_rf_datapath: vector table, directed register-file sequences, random model checks.
module tb_alu_rf_datapath;

   logic        clk;
   logic        rstn;
   logic [4:0]  rnum1, rnum2, wnum, aluc;
   logic [31:0] rdata1, rdata2, wdata, alua, alub, aluy;

   int total = 0;
   int bad   = 0;

   logic [31:0] model [0:31];

   alu_rf_datapath dut (
      .CLK    (clk),
      .RSTN   (rstn),
      .RNUM1  (rnum1),
      .RDATA1 (rdata1),
      .RNUM2  (rnum2),
      .RDATA2 (rdata2),
      .WNUM   (wnum),
      .WDATA  (wdata),
      .ALU_A  (alua),
      .ALU_B  (alub),
      .ALU_C  (aluc),
      .ALU_Y  (aluy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [4:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] y;
   } vec_t;

   vec_t vt [18];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%h want=%h", name, act, exp);
      end
   endtask

   // Reference ALU built from 64-bit integer arithmetic on the operand values.
   function automatic logic [31:0] ref_alu(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
      longint ua, ub, sa, sb, t;
      int     sh;
      ua = longint'({32'd0, a});
      ub = longint'({32'd0, b});
      sa = a[31] ? ua - 64'sd4294967296 : ua;
      sb = b[31] ? ub - 64'sd4294967296 : ub;
      sh = {27'd0, b[4:0]};
      case (op)
         5'd0:    t = ua + ub;
         5'd1:    t = ua - ub;
         5'd2:    t = ua << sh;
         5'd3:    t = (sa < sb) ? 64'd1 : 64'd0;
         5'd4:    t = (ua < ub) ? 64'd1 : 64'd0;
         5'd5:    t = ua ^ ub;
         5'd6:    t = ua >> sh;
         5'd7:    t = sa >>> sh;
         5'd8:    t = ua | ub;
         5'd9:    t = ua & ub;
         5'd10:   t = ub;
         default: t = 64'd0;
      endcase
      return t[31:0];
   endfunction

   function automatic logic [31:0] ref_rd(input logic [4:0] r, input logic [4:0] w, input logic [31:0] wd);
      if (r == 5'd0)     return 32'd0;
      else if (r == w)   return wd;
      else               return model[r];
   endfunction

   function automatic logic [31:0] pick_operand();
      case ($urandom_range(0, 5))
         0:       return 32'h0000_0000;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h8000_0000;
         3:       return 32'h7FFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   initial begin
      vt[0]  = '{"add_5_3",    5'd0,  32'd5,         32'd3,         32'd8};
      vt[1]  = '{"sub_5_3",    5'd1,  32'd5,         32'd3,         32'd2};
      vt[2]  = '{"sub_3_5",    5'd1,  32'd3,         32'd5,         32'hFFFF_FFFE};
      vt[3]  = '{"add_wrap",   5'd0,  32'hFFFF_FFFF, 32'd1,         32'd0};
      vt[4]  = '{"slt_neg",    5'd3,  32'hFFFF_FFFF, 32'd1,         32'd1};
      vt[5]  = '{"sltu_big",   5'd4,  32'hFFFF_FFFF, 32'd1,         32'd0};
      vt[6]  = '{"xor",        5'd5,  32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFE};
      vt[7]  = '{"or",         5'd8,  32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF};
      vt[8]  = '{"and",        5'd9,  32'hFFFF_FFFF, 32'd1,         32'd1};
      vt[9]  = '{"passb",      5'd10, 32'hFFFF_FFFF, 32'd1,         32'd1};
      vt[10] = '{"code20",     5'd20, 32'hFFFF_FFFF, 32'd1,         32'd0};
      vt[11] = '{"sll_33",     5'd2,  32'h8000_0001, 32'h0000_0021, 32'h0000_0002};
      vt[12] = '{"srl_33",     5'd6,  32'h8000_0001, 32'h0000_0021, 32'h4000_0000};
      vt[13] = '{"sra_33",     5'd7,  32'h8000_0001, 32'h0000_0021, 32'hC000_0000};
      vt[14] = '{"slt_pos",    5'd3,  32'd1,         32'hFFFF_FFFF, 32'd0};
      vt[15] = '{"sltu_small", 5'd4,  32'd1,         32'hFFFF_FFFF, 32'd1};
      vt[16] = '{"sra_31",     5'd7,  32'h8000_0000, 32'h0000_001F, 32'hFFFF_FFFF};
      vt[17] = '{"code11",     5'd11, 32'd5,         32'd3,         32'd0};

      rstn  = 1'b0;
      rnum1 = 5'd5;
      rnum2 = 5'd31;
      wnum  = 5'd0;
      wdata = 32'd0;
      alua  = 32'd0;
      alub  = 32'd0;
      aluc  = 5'd0;

      // ALU vector table (independent of clock/reset)
      for (int i = 0; i < 18; i++) begin
         alua = vt[i].a;
         alub = vt[i].b;
         aluc = vt[i].op;
         #1;
         chk(vt[i].name, aluy, vt[i].y);
      end

      // Reset state
      repeat (2) @(negedge clk);
      #1;
      chk("rst_x5", rdata1, 32'd0);
      chk("rst_x31", rdata2, 32'd0);
      rstn = 1'b1;

      // Write/read sequence
      @(negedge clk);
      wnum = 5'd1; wdata = 32'd5;
      @(negedge clk);
      wnum = 5'd2; wdata = 32'd3;
      @(negedge clk);
      wnum = 5'd0; wdata = 32'hDEAD_BEEF;
      rnum1 = 5'd1; rnum2 = 5'd2;
      #1;
      chk("rd_x1", rdata1, 32'd5);
      chk("rd_x2", rdata2, 32'd3);
      @(negedge clk);
      wnum = 5'd1; wdata = 32'd7;
      @(negedge clk);
      wnum = 5'd0;
      #1;
      chk("rd_x1_new", rdata1, 32'd7);
      chk("rd_x2_keep", rdata2, 32'd3);

      // Bypass
      @(negedge clk);
      wnum = 5'd3; wdata = 32'hCAFE_BABE;
      rnum1 = 5'd3; rnum2 = 5'd3;
      #1;
      chk("byp_p1", rdata1, 32'hCAFE_BABE);
      chk("byp_p2", rdata2, 32'hCAFE_BABE);
      @(negedge clk);
      wnum = 5'd0; rnum1 = 5'd0;
      #1;
      chk("x0_read", rdata1, 32'd0);
      chk("x3_stored", rdata2, 32'hCAFE_BABE);

      // Writes to x0 are discarded
      @(negedge clk);
      wnum = 5'd0; wdata = 32'hFFFF_FFFF;
      @(negedge clk);
      rnum1 = 5'd0;
      #1;
      chk("x0_after_wr", rdata1, 32'd0);

      // Asynchronous reset mid-run
      @(negedge clk);
      wnum = 5'd5; wdata = 32'h0000_1234;
      @(negedge clk);
      wnum = 5'd0; rnum1 = 5'd5; rnum2 = 5'd1;
      #1;
      chk("x5_before_rst", rdata1, 32'h0000_1234);
      rstn = 1'b0;
      #1;
      chk("x5_async_clr", rdata1, 32'd0);
      chk("x1_async_clr", rdata2, 32'd0);
      wnum = 5'd7; wdata = 32'h5555_AAAA; rnum2 = 5'd7;
      #1;
      chk("byp_in_rst", rdata2, 32'h5555_AAAA);
      @(posedge clk);
      #1;
      wnum = 5'd0;
      #1;
      chk("no_wr_in_rst", rdata2, 32'd0);
      @(negedge clk);
      rstn = 1'b1;
      for (int i = 0; i < 32; i++) model[i] = 32'd0;

      // Random register-file traffic and ALU operations against the models
      for (int n = 0; n < 400; n++) begin
         logic [4:0]  w, r1, r2;
         logic [31:0] wd;
         @(negedge clk);
         w  = $urandom_range(0, 1) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
         r1 = $urandom_range(0, 1) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
         r2 = ($urandom_range(0, 3) == 0) ? r1 : 5'($urandom_range(0, 31));
         wd = $urandom;
         wnum = w; wdata = wd; rnum1 = r1; rnum2 = r2;
         alua = pick_operand();
         alub = pick_operand();
         aluc = 5'($urandom_range(0, 15));
         #1;
         chk("rnd_rd1", rdata1, ref_rd(r1, w, wd));
         chk("rnd_rd2", rdata2, ref_rd(r2, w, wd));
         chk("rnd_alu", aluy, ref_alu(aluc, alua, alub));
         if (w != 5'd0) model[w] = wd;
      end

      // Every register ends up matching the model
      @(negedge clk);
      wnum = 5'd0;
      for (int i = 0; i < 32; i++) begin
         rnum1 = 5'(i);
         #1;
         chk("final_sweep", rdata1, ref_rd(5'(i), 5'd0, 32'd0));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
